tile_8x8: RTL and testbench

// - 8x8 output-stationary systolic MAC array; the compute core of the SA engine.
// - Activations (X) enter on the west edge, one per row, and move east one PE per cycle.
// - Weights (W) enter on the north edge, one per column, and move south one PE per cycle.
// - Every PE accumulates X*W in place; all 64 accumulators are exposed as outputs.
// - Upstream register file (RF) applies the skew; the tile does not skew internally.

---
 rtl/tile_pkg.sv | 14 +
 rtl/tile_pe.sv | 53 +++++
 rtl/tile_8x8.sv | 95 +++++++++
 tb/tb_tile_8x8.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared constants and types for the 8x8 output-stationary systolic MAC tile.
//   DW : operand width (activations X and weights W)
//   AW : accumulator width; 8 products of 255*255 sum to 520200 < 2^19
//   N  : array dimension (rows = columns), fixed
// Optional build macro TILE8X8_SIGNED_EN (consumed in tile_pe) selects
// two's-complement operands instead of unsigned ones.
package tile_pkg;
  localparam int DW = 8;
  localparam int AW = 19;
  localparam int N  = 8;

  typedef logic [DW-1:0] operand_t;
  typedef logic [AW-1:0] acc_t;
endpackage

// File: rtl/tile_pe.sv
// One processing element of the systolic tile: an X/W forwarding register
// pair plus an in-place multiply-accumulate register.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, clears all state
//   en     in   1 = advance pipeline and accumulate, 0 = hold everything
//   x_in   in   activation arriving from the west neighbour (or tile edge)
//   w_in   in   weight arriving from the north neighbour (or tile edge)
//   x_q    out  registered activation forwarded east
//   w_q    out  registered weight forwarded south
//   acc    out  running sum of x_in*w_in, wraps modulo 2^AW
// Build macro TILE8X8_SIGNED_EN: when defined the operands are signed and the
// product is sign-extended to AW; otherwise unsigned with zero extension.
module tile_pe
  import tile_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] w_in,
  output logic [DW-1:0] x_q,
  output logic [DW-1:0] w_q,
  output logic [AW-1:0] acc
);

  // Full 2*DW-bit product extended to the accumulator width.
  function automatic acc_t ext_product(input operand_t x, input operand_t w);
`ifdef TILE8X8_SIGNED_EN
    logic signed [2*DW-1:0] p;
    p = $signed({{DW{x[DW-1]}}, x}) * $signed({{DW{w[DW-1]}}, w});
    return {{(AW-2*DW){p[2*DW-1]}}, p};
`else
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, x} * {{DW{1'b0}}, w};
    return {{(AW-2*DW){1'b0}}, p};
`endif
  endfunction

  // Stage boundary: operands and partial sum registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      w_q <= '0;
      acc <= '0;
    end else if (en) begin
      x_q <= x_in;
      w_q <= w_in;
      acc <= acc + ext_product(x_in, w_in);
    end
  end

endmodule

// File: rtl/tile_8x8.sv
// 8x8 output-stationary systolic MAC array (compute core of the SA engine).
// Activations enter on the west edge and shift east one PE per enabled cycle;
// weights enter on the north edge and shift south one PE per enabled cycle.
// Every PE accumulates X*W in place. Input skew is applied upstream.
// Ports:
//   CLK              in   clock, rising edge
//   RST              in   asynchronous active-low reset
//   EN               in   global enable; 0 freezes every register
//   N_R0X..N_R7X     in   DW  west-edge activation per row
//   N_C0X..N_C7X     in   DW  north-edge weight per column
//   Y_00..Y_77       out  AW  accumulator of PE(row, col)
//   N_R0Y..N_R7Y     out  AW  X leaving the east edge, zero-extended
//   N_C0Y..N_C7Y     out  AW  W leaving the south edge, zero-extended
// Build macro TILE8X8_SIGNED_EN: signed operands/results (edge outputs still
// zero-extend).
module tile_8x8
  import tile_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic [DW-1:0] N_R0X, N_R1X, N_R2X, N_R3X, N_R4X, N_R5X, N_R6X, N_R7X,
  input  logic [DW-1:0] N_C0X, N_C1X, N_C2X, N_C3X, N_C4X, N_C5X, N_C6X, N_C7X,
  output logic [AW-1:0] Y_00, Y_01, Y_02, Y_03, Y_04, Y_05, Y_06, Y_07,
  output logic [AW-1:0] Y_10, Y_11, Y_12, Y_13, Y_14, Y_15, Y_16, Y_17,
  output logic [AW-1:0] Y_20, Y_21, Y_22, Y_23, Y_24, Y_25, Y_26, Y_27,
  output logic [AW-1:0] Y_30, Y_31, Y_32, Y_33, Y_34, Y_35, Y_36, Y_37,
  output logic [AW-1:0] Y_40, Y_41, Y_42, Y_43, Y_44, Y_45, Y_46, Y_47,
  output logic [AW-1:0] Y_50, Y_51, Y_52, Y_53, Y_54, Y_55, Y_56, Y_57,
  output logic [AW-1:0] Y_60, Y_61, Y_62, Y_63, Y_64, Y_65, Y_66, Y_67,
  output logic [AW-1:0] Y_70, Y_71, Y_72, Y_73, Y_74, Y_75, Y_76, Y_77,
  output logic [AW-1:0] N_R0Y, N_R1Y, N_R2Y, N_R3Y, N_R4Y, N_R5Y, N_R6Y, N_R7Y,
  output logic [AW-1:0] N_C0Y, N_C1Y, N_C2Y, N_C3Y, N_C4Y, N_C5Y, N_C6Y, N_C7Y
);

  // x_bus[r][c] feeds PE(r,c); PE(r,c) drives x_bus[r][c+1]. Column 0 is the
  // west port, column N is the east cascade. w_bus is the same idea vertically.
  logic [DW-1:0] x_bus [N][N+1];
  logic [DW-1:0] w_bus [N+1][N];
  logic [AW-1:0] acc   [N][N];

  assign x_bus[0][0] = N_R0X;  assign x_bus[1][0] = N_R1X;
  assign x_bus[2][0] = N_R2X;  assign x_bus[3][0] = N_R3X;
  assign x_bus[4][0] = N_R4X;  assign x_bus[5][0] = N_R5X;
  assign x_bus[6][0] = N_R6X;  assign x_bus[7][0] = N_R7X;

  assign w_bus[0][0] = N_C0X;  assign w_bus[0][1] = N_C1X;
  assign w_bus[0][2] = N_C2X;  assign w_bus[0][3] = N_C3X;
  assign w_bus[0][4] = N_C4X;  assign w_bus[0][5] = N_C5X;
  assign w_bus[0][6] = N_C6X;  assign w_bus[0][7] = N_C7X;

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      tile_pe u_pe (
        .clk   (CLK),
        .rst_n (RST),
        .en    (EN),
        .x_in  (x_bus[r][c]),
        .w_in  (w_bus[r][c]),
        .x_q   (x_bus[r][c+1]),
        .w_q   (w_bus[r+1][c]),
        .acc   (acc[r][c])
      );
    end
  end

  assign Y_00 = acc[0][0]; assign Y_01 = acc[0][1]; assign Y_02 = acc[0][2]; assign Y_03 = acc[0][3];
  assign Y_04 = acc[0][4]; assign Y_05 = acc[0][5]; assign Y_06 = acc[0][6]; assign Y_07 = acc[0][7];
  assign Y_10 = acc[1][0]; assign Y_11 = acc[1][1]; assign Y_12 = acc[1][2]; assign Y_13 = acc[1][3];
  assign Y_14 = acc[1][4]; assign Y_15 = acc[1][5]; assign Y_16 = acc[1][6]; assign Y_17 = acc[1][7];
  assign Y_20 = acc[2][0]; assign Y_21 = acc[2][1]; assign Y_22 = acc[2][2]; assign Y_23 = acc[2][3];
  assign Y_24 = acc[2][4]; assign Y_25 = acc[2][5]; assign Y_26 = acc[2][6]; assign Y_27 = acc[2][7];
  assign Y_30 = acc[3][0]; assign Y_31 = acc[3][1]; assign Y_32 = acc[3][2]; assign Y_33 = acc[3][3];
  assign Y_34 = acc[3][4]; assign Y_35 = acc[3][5]; assign Y_36 = acc[3][6]; assign Y_37 = acc[3][7];
  assign Y_40 = acc[4][0]; assign Y_41 = acc[4][1]; assign Y_42 = acc[4][2]; assign Y_43 = acc[4][3];
  assign Y_44 = acc[4][4]; assign Y_45 = acc[4][5]; assign Y_46 = acc[4][6]; assign Y_47 = acc[4][7];
  assign Y_50 = acc[5][0]; assign Y_51 = acc[5][1]; assign Y_52 = acc[5][2]; assign Y_53 = acc[5][3];
  assign Y_54 = acc[5][4]; assign Y_55 = acc[5][5]; assign Y_56 = acc[5][6]; assign Y_57 = acc[5][7];
  assign Y_60 = acc[6][0]; assign Y_61 = acc[6][1]; assign Y_62 = acc[6][2]; assign Y_63 = acc[6][3];
  assign Y_64 = acc[6][4]; assign Y_65 = acc[6][5]; assign Y_66 = acc[6][6]; assign Y_67 = acc[6][7];
  assign Y_70 = acc[7][0]; assign Y_71 = acc[7][1]; assign Y_72 = acc[7][2]; assign Y_73 = acc[7][3];
  assign Y_74 = acc[7][4]; assign Y_75 = acc[7][5]; assign Y_76 = acc[7][6]; assign Y_77 = acc[7][7];

  // Cascade outputs are always zero-extended, even in the signed build.
  assign N_R0Y = acc_t'(x_bus[0][N]);  assign N_R1Y = acc_t'(x_bus[1][N]);
  assign N_R2Y = acc_t'(x_bus[2][N]);  assign N_R3Y = acc_t'(x_bus[3][N]);
  assign N_R4Y = acc_t'(x_bus[4][N]);  assign N_R5Y = acc_t'(x_bus[5][N]);
  assign N_R6Y = acc_t'(x_bus[6][N]);  assign N_R7Y = acc_t'(x_bus[7][N]);

  assign N_C0Y = acc_t'(w_bus[N][0]);  assign N_C1Y = acc_t'(w_bus[N][1]);
  assign N_C2Y = acc_t'(w_bus[N][2]);  assign N_C3Y = acc_t'(w_bus[N][3]);
  assign N_C4Y = acc_t'(w_bus[N][4]);  assign N_C5Y = acc_t'(w_bus[N][5]);
  assign N_C6Y = acc_t'(w_bus[N][6]);  assign N_C7Y = acc_t'(w_bus[N][7]);

endmodule

// File: tb/tb_tile_8x8.sv
module tb_tile_8x8;

  logic CLK = 1'b0;
  logic RST;
  logic EN;
  logic [7:0][7:0]        rx;
  logic [7:0][7:0]        cx;
  logic [7:0][7:0][18:0]  y;
  logic [7:0][18:0]       ry;
  logic [7:0][18:0]       cy;

  int a [8][8];
  int b [8][8];
  int n_asserts = 0;
  int n_fail    = 0;

  always #5 CLK = ~CLK;

  tile_8x8 dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .N_R0X(rx[0]), .N_R1X(rx[1]), .N_R2X(rx[2]), .N_R3X(rx[3]),
    .N_R4X(rx[4]), .N_R5X(rx[5]), .N_R6X(rx[6]), .N_R7X(rx[7]),
    .N_C0X(cx[0]), .N_C1X(cx[1]), .N_C2X(cx[2]), .N_C3X(cx[3]),
    .N_C4X(cx[4]), .N_C5X(cx[5]), .N_C6X(cx[6]), .N_C7X(cx[7]),
    .Y_00(y[0][0]), .Y_01(y[0][1]), .Y_02(y[0][2]), .Y_03(y[0][3]), .Y_04(y[0][4]), .Y_05(y[0][5]), .Y_06(y[0][6]), .Y_07(y[0][7]),
    .Y_10(y[1][0]), .Y_11(y[1][1]), .Y_12(y[1][2]), .Y_13(y[1][3]), .Y_14(y[1][4]), .Y_15(y[1][5]), .Y_16(y[1][6]), .Y_17(y[1][7]),
    .Y_20(y[2][0]), .Y_21(y[2][1]), .Y_22(y[2][2]), .Y_23(y[2][3]), .Y_24(y[2][4]), .Y_25(y[2][5]), .Y_26(y[2][6]), .Y_27(y[2][7]),
    .Y_30(y[3][0]), .Y_31(y[3][1]), .Y_32(y[3][2]), .Y_33(y[3][3]), .Y_34(y[3][4]), .Y_35(y[3][5]), .Y_36(y[3][6]), .Y_37(y[3][7]),
    .Y_40(y[4][0]), .Y_41(y[4][1]), .Y_42(y[4][2]), .Y_43(y[4][3]), .Y_44(y[4][4]), .Y_45(y[4][5]), .Y_46(y[4][6]), .Y_47(y[4][7]),
    .Y_50(y[5][0]), .Y_51(y[5][1]), .Y_52(y[5][2]), .Y_53(y[5][3]), .Y_54(y[5][4]), .Y_55(y[5][5]), .Y_56(y[5][6]), .Y_57(y[5][7]),
    .Y_60(y[6][0]), .Y_61(y[6][1]), .Y_62(y[6][2]), .Y_63(y[6][3]), .Y_64(y[6][4]), .Y_65(y[6][5]), .Y_66(y[6][6]), .Y_67(y[6][7]),
    .Y_70(y[7][0]), .Y_71(y[7][1]), .Y_72(y[7][2]), .Y_73(y[7][3]), .Y_74(y[7][4]), .Y_75(y[7][5]), .Y_76(y[7][6]), .Y_77(y[7][7]),
    .N_R0Y(ry[0]), .N_R1Y(ry[1]), .N_R2Y(ry[2]), .N_R3Y(ry[3]),
    .N_R4Y(ry[4]), .N_R5Y(ry[5]), .N_R6Y(ry[6]), .N_R7Y(ry[7]),
    .N_C0Y(cy[0]), .N_C1Y(cy[1]), .N_C2Y(cy[2]), .N_C3Y(cy[3]),
    .N_C4Y(cy[4]), .N_C5Y(cy[5]), .N_C6Y(cy[6]), .N_C7Y(cy[7])
  );

  // Expected Y(r,c) after t enabled cycles of a skewed A*B run:
  // term k lands in PE(r,c) on enabled cycle r+k+c.
  function automatic logic [18:0] exp_y(input int r, input int c, input int t);
    int s;
    s = 0;
    for (int k = 0; k < 8; k++)
      if (r + k + c <= t - 1) s += a[r][k] * b[k][c];
    return s[18:0];
  endfunction

  // East edge of row r after t cycles shows the west input of cycle t-8.
  function automatic logic [18:0] exp_rx(input int r, input int t);
    int k;
    logic [7:0] v;
    k = t - 8 - r;
    v = (k >= 0 && k < 8) ? 8'(a[r][k]) : 8'd0;
    return {11'd0, v};
  endfunction

  function automatic logic [18:0] exp_cx(input int c, input int t);
    int k;
    logic [7:0] v;
    k = t - 8 - c;
    v = (k >= 0 && k < 8) ? 8'(b[k][c]) : 8'd0;
    return {11'd0, v};
  endfunction

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int t);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        chk($sformatf("%s Y_%0d%0d", tag, r, c), y[r][c], exp_y(r, c, t));
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s N_R%0dY", tag, i), ry[i], exp_rx(i, t));
      chk($sformatf("%s N_C%0dY", tag, i), cy[i], exp_cx(i, t));
    end
  endtask

  task automatic check_y_const(input string tag, input logic [18:0] v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        chk($sformatf("%s Y_%0d%0d", tag, r, c), y[r][c], v);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_inputs(input int t);
    for (int i = 0; i < 8; i++) begin
      rx[i] = (t - i >= 0 && t - i < 8) ? 8'(a[i][t-i]) : 8'd0;
      cx[i] = (t - i >= 0 && t - i < 8) ? 8'(b[t-i][i]) : 8'd0;
    end
  endtask

  task automatic run(input int t0, input int t1);
    for (int t = t0; t < t1; t++) begin
      set_inputs(t);
      EN = 1'b1;
      tick();
    end
    rx = '0;
    cx = '0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    EN  = 1'b0;
    rx  = '0;
    cx  = '0;
    tick();
    RST = 1'b1;
  endtask

  task automatic load_identity();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        a[i][j] = (i == j) ? 1 : 0;
        b[i][j] = 8 * i + j;
      end
  endtask

  task automatic load_const(input int v);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        a[i][j] = v;
        b[i][j] = v;
      end
  endtask

  initial begin
    // Reset held with random inputs and EN high: everything stays 0.
    RST = 1'b0;
    EN  = 1'b1;
    load_const(0);
    for (int i = 0; i < 3; i++) begin
      rx = {$urandom, $urandom};
      cx = {$urandom, $urandom};
      tick();
    end
    check_all("reset", 0);
    rx = '0;
    cx = '0;
    RST = 1'b1;

    // Identity: Y_rc = 8r+c after 22 enabled cycles; also a partial point.
    load_identity();
    run(0, 12);
    check_all("ident_t12", 12);
    run(12, 22);
    check_all("ident", 22);

    // EN gating mid-run with garbage on the inputs.
    do_reset();
    check_all("rst_between", 0);
    run(0, 10);
    check_all("pre_gate", 10);
    for (int i = 0; i < 5; i++) begin
      EN = 1'b0;
      rx = {$urandom, $urandom};
      cx = {$urandom, $urandom};
      tick();
      check_all("gated_hold", 10);
    end
    run(10, 22);
    check_all("gated_final", 22);

    // Mid-operation reset: outputs clear before any clock edge.
    do_reset();
    run(0, 10);
    check_all("before_midrst", 10);
    RST = 1'b0;
    #1;
    check_all("midrst_async", 0);
    tick();
    RST = 1'b1;
    run(0, 22);
    check_all("after_midrst", 22);

    // Propagation of a single west value on row 3.
    do_reset();
    EN = 1'b1;
    rx[3] = 8'd7;
    tick();
    rx[3] = 8'd0;
    for (int i = 1; i <= 9; i++) begin
      chk($sformatf("prop_r3 edge%0d", i), ry[3], (i == 8) ? 19'd7 : 19'd0);
      if (i >= 8) check_y_const($sformatf("prop_r3 y%0d", i), 19'd0);
      tick();
    end

    // Propagation of a single north value on column 5.
    do_reset();
    EN = 1'b1;
    cx[5] = 8'd7;
    tick();
    cx[5] = 8'd0;
    for (int i = 1; i <= 9; i++) begin
      chk($sformatf("prop_c5 edge%0d", i), cy[5], (i == 8) ? 19'd7 : 19'd0);
      if (i >= 8) check_y_const($sformatf("prop_c5 y%0d", i), 19'd0);
      tick();
    end

`ifndef TILE8X8_SIGNED_EN
    // Max operands: 8*255*255 = 520200, then one more wavefront wraps.
    do_reset();
    load_const(255);
    run(0, 22);
    check_y_const("max", 19'd520200);
    for (int t = 0; t < 15; t++) begin
      for (int i = 0; i < 8; i++) begin
        rx[i] = (t == i) ? 8'd255 : 8'd0;
        cx[i] = (t == i) ? 8'd255 : 8'd0;
      end
      EN = 1'b1;
      tick();
    end
    check_y_const("max_wrap", 19'd60937);
`else
    // Signed extreme: 8 * (-128 * -128) = 131072.
    do_reset();
    load_const(-128);
    run(0, 22);
    check_y_const("signed_min", 19'd131072);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
